uart_tx_fifo: RTL

UART transmitter with a small byte FIFO, the transmit-side counterpart of the board's UART receive path. It accepts bytes from the FPGA fabric, for example status or sensor values destined for the host, and serialises them as 8N1 frames, LSB first, on `o_uart_serial`. Its baud timing is set by the same clocks-per-bit scheme as the receiver, so both directions share one baud rate.

---
 rtl/uart_tx_fifo.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed from a small circular byte FIFO.
// Frames go out LSB first; a queued byte starts the next frame with no idle gap.
//
// state    | meaning
// ---------+----------------------------------------------
// ST_IDLE  | line high, waiting for the FIFO to hold a byte
// ST_START | start bit (line low)
// ST_DATA  | eight data bits, shift[0] on the line
// ST_STOP  | stop bit (line high), o_done on its last cycle
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_wr_en,
  input  logic [7:0] i_wr_data,
  output logic       o_full,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_uart_serial
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;
  logic              full_q;

  logic [1:0]        state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift;
  logic              serial_q;

  logic              baud_last;
  logic              fifo_nonempty;
  logic              push;
  logic              pop;

  assign baud_last     = (baud_cnt == BAUD_LAST);
  assign fifo_nonempty = (count != '0);
  // A write against a full FIFO is dropped even if a pop frees a slot on the same edge.
  assign push          = i_wr_en & ~full_q;
  assign pop           = fifo_nonempty &
                         ((state == ST_IDLE) | ((state == ST_STOP) & baud_last));

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      full_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count  <= count_next;
      full_q <= (count_next == CNT_FULL);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      serial_q <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          serial_q <= 1'b1;
          baud_cnt <= '0;
          if (fifo_nonempty) begin
            shift    <= mem[rd_ptr];
            state    <= ST_START;
            serial_q <= 1'b0;
          end
        end
        ST_START: begin
          if (baud_last) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= ST_DATA;
            serial_q <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state    <= ST_STOP;
              serial_q <= 1'b1;
            end else begin
              shift    <= {1'b0, shift[7:1]};
              bit_idx  <= bit_idx + 3'd1;
              serial_q <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            // Back-to-back: reload straight into the start bit.
            if (fifo_nonempty) begin
              shift    <= mem[rd_ptr];
              state    <= ST_START;
              serial_q <= 1'b0;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          serial_q <= 1'b1;
        end
      endcase
    end
  end

  assign o_uart_serial = serial_q;
  assign o_full        = full_q;
  assign o_busy        = (state != ST_IDLE) | fifo_nonempty;
  assign o_done        = (state == ST_STOP) & baud_last;

endmodule
